// File: rtl/lfsr_pkg.sv
// Shared types and LFSR helpers for the two-requester LFSR arbiter.
package lfsr_pkg;
  localparam int              LFSR_W    = 6;
  localparam logic [LFSR_W-1:0] LFSR_RST  = 6'h3F;
  // Feedback XOR positions q1, q2, q4; q0 takes q5 directly via the rotate.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 6'b010110;

  typedef enum logic {IDLE, BURST} state_t;

  // One Galois step: rotate left, then fold the outgoing MSB into the taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[LFSR_W-1]} ^ (q[LFSR_W-1] ? LFSR_TAPS : '0);
  endfunction
endpackage

// File: rtl/lfsr_arbiter_if.sv
// Requester-side bus of the LFSR arbiter. Seed ports exist only when
// LFSR_SEED_EN is defined.
interface lfsr_arbiter_if;
  import lfsr_pkg::*;
  logic [1:0]        req;
  logic [1:0]        rdy;
  logic [1:0]        gnt;
  logic              valid;
  logic [LFSR_W-1:0] data;
  logic              last;
  logic [1:0]        done;
`ifdef LFSR_SEED_EN
  logic              seed_ld;
  logic [LFSR_W-1:0] seed;
`endif

  modport slave (
    input  req, rdy,
`ifdef LFSR_SEED_EN
    input  seed_ld, seed,
`endif
    output gnt, valid, data, last, done
  );

  modport master (
    output req, rdy,
`ifdef LFSR_SEED_EN
    output seed_ld, seed,
`endif
    input  gnt, valid, data, last, done
  );
endinterface

// File: rtl/lfsr6_core.sv
// 6-bit Galois LFSR register: reset to LFSR_RST, load has priority over step.
module lfsr6_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] din,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] r_q;

  // Hold unless loaded or stepped by an accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_q <= LFSR_RST;
    else if (load) r_q <= din;
    else if (step) r_q <= lfsr_next(r_q);
  end

  assign q = r_q;
endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one LFSR between two requesters; each grant
// delivers BURST_LEN words over valid/ready. Optional macro LFSR_SEED_EN
// adds an IDLE-only seed load.
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 6
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_arbiter_if.slave  bus
);
  state_t            r_state;
  logic              r_rr_last;
  logic              r_win;
  logic [1:0]        r_gnt;
  logic              r_valid;
  logic              r_last;
  logic [1:0]        r_done;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_acc;
  logic              w_req_w;
  logic              w_pick;
  logic              w_seed_ld;
  logic [LFSR_W-1:0] w_seed;
  logic [LFSR_W-1:0] w_q;

  // Only the granted requester's rdy/req matter; r_gnt is 0 outside BURST.
  assign w_acc   = (r_state == BURST) && |(bus.rdy & r_gnt);
  assign w_req_w = |(bus.req & r_gnt);
  assign w_pick  = (bus.req == 2'b11) ? ~r_rr_last : bus.req[1];

`ifdef LFSR_SEED_EN
  assign w_seed_ld = (r_state == IDLE) && bus.seed_ld;
  assign w_seed    = (bus.seed == '0) ? LFSR_RST : bus.seed;
`else
  assign w_seed_ld = 1'b0;
  assign w_seed    = LFSR_RST;
`endif

  lfsr6_core u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (w_acc),
    .load (w_seed_ld),
    .din  (w_seed),
    .q    (w_q)
  );

  // Arbiter FSM with registered grant/valid/last/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_win     <= 1'b0;
      r_gnt     <= 2'b00;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 2'b00;
      r_cnt     <= '0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        IDLE: begin
          // A seed load takes the cycle; any grant waits one more cycle.
          if (!w_seed_ld && bus.req != 2'b00) begin
            r_win   <= w_pick;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_last  <= (BURST_LEN == 1);
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_acc) begin
            if (r_last) begin
              r_done    <= r_gnt;
              r_gnt     <= 2'b00;
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_rr_last <= r_win;
              r_state   <= IDLE;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_last <= ((r_cnt + 1'b1) == CNT_W'(BURST_LEN - 1));
            end
          end else if (!w_req_w) begin
            // Abort: requester withdrew mid-burst; no done pulse.
            r_gnt     <= 2'b00;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_rr_last <= r_win;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.valid = r_valid;
  assign bus.data  = w_q;
  assign bus.last  = r_last;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_lfsr_arbiter.sv
// Randomized bench for lfsr_arbiter against a cycle-level behavioural model.
module tb_lfsr_arbiter;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  lfsr_arbiter_if bus ();

  lfsr_arbiter #(.BURST_LEN(BL), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit       m_busy;
  int       m_owner;
  int       m_beats;
  int       m_rr;
  bit [5:0] m_lfsr;
  bit [1:0] m_done;
  bit       t_seed_ld;
  bit [5:0] t_seed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit equations of the polynomial written out one by one.
  function automatic bit [5:0] m_step(input bit [5:0] q);
    return {q[4], q[3] ^ q[5], q[2], q[1] ^ q[5], q[0] ^ q[5], q[5]};
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_rr = 1; m_lfsr = 6'h3F; m_done = 0;
  endfunction

  // Apply one clock edge of the protocol rules to the model.
  function automatic void m_edge(input bit [1:0] rq, input bit [1:0] rd);
    m_done = 0;
    if (!m_busy) begin
      if (t_seed_ld) begin
        m_lfsr = (t_seed == 0) ? 6'h3F : t_seed;
      end else if (rq != 0) begin
        if (rq == 2'b11) m_owner = 1 - m_rr;
        else             m_owner = rq[1] ? 1 : 0;
        m_busy  = 1;
        m_beats = 0;
      end
    end else if (rd[m_owner]) begin
      m_lfsr = m_step(m_lfsr);
      if (m_beats == BL - 1) begin
        m_busy = 0;
        m_done[m_owner] = 1'b1;
        m_rr = m_owner;
      end else begin
        m_beats++;
      end
    end else if (!rq[m_owner]) begin
      m_busy = 0;
      m_rr = m_owner;
    end
  endfunction

  task automatic cycle(input logic [1:0] rq, input logic [1:0] rd);
    bit [1:0] eg;
    @(negedge clk);
    bus.req = rq;
    bus.rdy = rd;
`ifdef LFSR_SEED_EN
    bus.seed_ld = t_seed_ld;
    bus.seed    = t_seed;
`endif
    m_edge(rq, rd);
    @(posedge clk);
    #1;
    eg = m_busy ? (2'b01 << m_owner) : 2'b00;
    chk("gnt",   32'(bus.gnt),   32'(eg));
    chk("valid", 32'(bus.valid), 32'(m_busy));
    chk("data",  32'(bus.data),  32'(m_lfsr));
    chk("last",  32'(bus.last),  32'(m_busy && m_beats == BL - 1));
    chk("done",  32'(bus.done),  32'(m_done));
  endtask

  // Async reset away from any clock edge; outputs must clear at once.
  task automatic async_reset();
    bus.req = 0;
    bus.rdy = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_gnt",   32'(bus.gnt),   0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_last",  32'(bus.last),  0);
    chk("rst_done",  32'(bus.done),  0);
    chk("rst_data",  32'(bus.data),  32'h3F);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [5:0] exp_seq [4];
    logic [1:0] rq;
    exp_seq[0] = 6'h3F; exp_seq[1] = 6'h29; exp_seq[2] = 6'h05; exp_seq[3] = 6'h0A;
    t_seed_ld = 0;
    t_seed    = 0;
    bus.req = 0;
    bus.rdy = 0;
`ifdef LFSR_SEED_EN
    bus.seed_ld = 0;
    bus.seed    = 0;
`endif
    m_reset();
    #12;
    chk("por_gnt",  32'(bus.gnt),  0);
    chk("por_data", 32'(bus.data), 32'h3F);
    @(negedge clk);
    rst = 1'b1;

    // Single burst for requester 0.
    for (int i = 0; i < BL; i++) begin
      cycle(2'b01, 2'b01);
      chk("seq_data", 32'(bus.data), 32'(exp_seq[i]));
      chk("seq_gnt",  32'(bus.gnt),  32'h1);
    end
    chk("seq_last", 32'(bus.last), 1);
    cycle(2'b00, 2'b01);
    chk("seq_done", 32'(bus.done), 32'h1);
    chk("seq_idle", 32'(bus.gnt),  0);

    // Both requesting: 0 then 1 (first word 14) then 0.
    async_reset();
    cycle(2'b11, 2'b11);
    chk("alt_g0", 32'(bus.gnt), 32'h1);
    repeat (BL) cycle(2'b11, 2'b11);
    chk("alt_idle", 32'(bus.gnt), 0);
    cycle(2'b11, 2'b11);
    chk("alt_g1", 32'(bus.gnt), 32'h2);
    chk("alt_w1", 32'(bus.data), 32'h14);
    repeat (BL + 1) cycle(2'b11, 2'b11);
    chk("alt_g2", 32'(bus.gnt), 32'h1);

    // Stall: rdy low holds the word and counts no beat.
    async_reset();
    cycle(2'b01, 2'b00);
    repeat (3) cycle(2'b01, 2'b10);
    chk("stall_data",  32'(bus.data),  32'h3F);
    chk("stall_valid", 32'(bus.valid), 1);

    // Abort after two accepted beats; requester 1 takes over at word 05.
    async_reset();
    cycle(2'b01, 2'b01);
    cycle(2'b01, 2'b01);
    cycle(2'b01, 2'b01);
    cycle(2'b10, 2'b00);
    chk("abort_gnt",  32'(bus.gnt),  0);
    chk("abort_done", 32'(bus.done), 0);
    cycle(2'b10, 2'b00);
    chk("abort_g1",   32'(bus.gnt),  32'h2);
    chk("abort_data", 32'(bus.data), 32'h05);

    // Mid-burst asynchronous reset.
    cycle(2'b10, 2'b10);
    async_reset();

`ifdef LFSR_SEED_EN
    cycle(2'b00, 2'b00);
    t_seed_ld = 1; t_seed = 6'h00;
    cycle(2'b01, 2'b01);
    chk("seed0", 32'(bus.data), 32'h3F);
    t_seed = 6'h01;
    cycle(2'b01, 2'b01);
    chk("seed_nogrant", 32'(bus.gnt), 0);
    t_seed_ld = 0;
    cycle(2'b01, 2'b01);
    chk("seed_w0", 32'(bus.data), 32'h01);
    cycle(2'b01, 2'b01);
    chk("seed_w1", 32'(bus.data), 32'h02);
`endif

    // Random traffic: granted requester holds req except for rare aborts.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_busy && m_owner == i) rq[i] = ($urandom_range(0, 31) != 0);
        else                        rq[i] = 1'($urandom_range(0, 1));
      end
`ifdef LFSR_SEED_EN
      t_seed_ld = ($urandom_range(0, 7) == 0);
      t_seed    = 6'($urandom);
`endif
      cycle(rq, 2'($urandom));
      if (n == 1500) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
